// File: rtl/vga_timing.sv
// vga_timing: 640x480 VGA timing generator with a pixel-rate divider,
// active-area coordinates for the layer stage, and sync/enable pipeline
// matched to the layer RAM read latency so rgb, hs and vs stay aligned.
// Optional build macro: VGA_TIMING_BORDER_EN draws a white 1-pixel frame
// around the active area.
module vga_timing #(
   parameter int PIX_DIV = 4,
   parameter int RD_LAT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] color_in,
   output logic [9:0]  vga_x,
   output logic [8:0]  vga_y,
   output logic        pix_en,
   output logic        hs,
   output logic        vs,
   output logic [11:0] rgb,
   output logic        frame_end
);

   localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] H_SYNC_S = 10'd656;
   localparam logic [9:0] H_SYNC_E = 10'd751;
   localparam logic [9:0] H_LAST   = 10'd799;
   localparam logic [8:0] V_ACTIVE = 9'd480;
   localparam logic [8:0] V_SYNC_S = 9'd490;
   localparam logic [8:0] V_SYNC_E = 9'd491;
   localparam logic [8:0] V_LAST   = 9'd524;

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_h_cnt;
   logic [8:0]       r_v_cnt;
   logic [9:0]       r_vga_x;
   logic [8:0]       r_vga_y;
   logic [RD_LAT:0]  r_hs_pipe;
   logic [RD_LAT:0]  r_vs_pipe;
   logic [11:0]      r_rgb;

   logic             w_pix_en;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic [9:0]       w_h_nxt;
   logic [8:0]       w_v_nxt;
   logic             w_de_raw;
   logic             w_hs_raw;
   logic             w_vs_raw;
   logic [RD_LAT:0]  w_de_all;
   logic             w_de_tap;
   logic [11:0]      w_rgb_nxt;

   // Pixel-rate divider: free-running 0..PIX_DIV-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_div <= '0;
      else if (r_div == DIV_LAST) r_div <= '0;
      else                       r_div <= r_div + 1'b1;
   end

   // Gating with rst keeps the strobe low in reset even when PIX_DIV=1.
   assign w_pix_en = (r_div == DIV_LAST) && !rst;
   assign w_h_wrap = (r_h_cnt == H_LAST);
   assign w_v_wrap = (r_v_cnt == V_LAST);

   // Next raster position; both counters wrap on the same pixel strobe.
   always_comb begin
      w_h_nxt = r_h_cnt;
      w_v_nxt = r_v_cnt;
      if (w_pix_en) begin
         w_h_nxt = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
         if (w_h_wrap) w_v_nxt = w_v_wrap ? 9'd0 : r_v_cnt + 9'd1;
      end
   end

   // Raster counters and active-area coordinates update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
         r_vga_x <= '0;
         r_vga_y <= '0;
      end else begin
         r_h_cnt <= w_h_nxt;
         r_v_cnt <= w_v_nxt;
         r_vga_x <= (w_h_nxt < H_ACTIVE) ? w_h_nxt : 10'd0;
         r_vga_y <= (w_v_nxt < V_ACTIVE) ? w_v_nxt : 9'd0;
      end
   end

   assign w_de_raw = (r_h_cnt < H_ACTIVE) && (r_v_cnt < V_ACTIVE);
   assign w_hs_raw = !((r_h_cnt >= H_SYNC_S) && (r_h_cnt <= H_SYNC_E));
   assign w_vs_raw = !((r_v_cnt >= V_SYNC_S) && (r_v_cnt <= V_SYNC_E));

   // Sync delay line: RD_LAT+1 stages so sync lines up with registered rgb.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs_pipe <= '1;
         r_vs_pipe <= '1;
      end else begin
         r_hs_pipe[0] <= w_hs_raw;
         r_vs_pipe[0] <= w_vs_raw;
         for (int i = 1; i <= RD_LAT; i++) begin
            r_hs_pipe[i] <= r_hs_pipe[i-1];
            r_vs_pipe[i] <= r_vs_pipe[i-1];
         end
      end
   end

   // The enable only needs RD_LAT flops; the rgb register is its last stage.
   assign w_de_all[0] = w_de_raw;
   generate
      if (RD_LAT > 0) begin : g_de_pipe
         logic [RD_LAT-1:0] r_de_pipe;
         // Active-window delay matching the layer RAM latency.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_de_pipe <= '0;
            else     r_de_pipe <= w_de_all[RD_LAT-1:0];
         end
         assign w_de_all[RD_LAT:1] = r_de_pipe;
      end
   endgenerate
   assign w_de_tap = w_de_all[RD_LAT];

`ifdef VGA_TIMING_BORDER_EN
   logic            w_bd_raw;
   logic [RD_LAT:0] w_bd_all;
   logic            w_bd_tap;

   assign w_bd_raw = w_de_raw && ((r_h_cnt == 10'd0) || (r_h_cnt == H_ACTIVE - 10'd1) ||
                                  (r_v_cnt == 9'd0)  || (r_v_cnt == V_ACTIVE - 9'd1));
   assign w_bd_all[0] = w_bd_raw;
   generate
      if (RD_LAT > 0) begin : g_bd_pipe
         logic [RD_LAT-1:0] r_bd_pipe;
         // Border flag travels alongside the active-window flag.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_bd_pipe <= '0;
            else     r_bd_pipe <= w_bd_all[RD_LAT-1:0];
         end
         assign w_bd_all[RD_LAT:1] = r_bd_pipe;
      end
   endgenerate
   assign w_bd_tap = w_bd_all[RD_LAT];

   // Colour select: blank outside the window, white on the frame edge.
   always_comb begin
      w_rgb_nxt = 12'h000;
      if (w_de_tap) w_rgb_nxt = w_bd_tap ? 12'hFFF : color_in;
   end
`else
   // Colour select: blank outside the delayed active window.
   always_comb begin
      w_rgb_nxt = 12'h000;
      if (w_de_tap) w_rgb_nxt = color_in;
   end
`endif

   // Output colour register, aligned with the last sync stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rgb <= 12'h000;
      else     r_rgb <= w_rgb_nxt;
   end

   assign vga_x     = r_vga_x;
   assign vga_y     = r_vga_y;
   assign pix_en    = w_pix_en;
   assign hs        = r_hs_pipe[RD_LAT];
   assign vs        = r_vs_pipe[RD_LAT];
   assign rgb       = r_rgb;
   assign frame_end = w_pix_en && w_h_wrap && w_v_wrap;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter PIX_DIV, default 4: clk cycles per pixel (100 MHz clk gives a 25 MHz pixel rate).
REQ-002 Parameter RD_LAT, default 1: clk cycles from a vga_x/vga_y change to the matching color_in being valid (layer RAM read latency).
REQ-003 Port clk  input  1: single system clock; all state on posedge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port color_in  input  12: pixel colour from the layer stage, {R[3:0],G[3:0],B[3:0]}.
REQ-006 Port vga_x  output  10: active-area column 0..639 driven to the layer stage.
REQ-007 Port vga_y  output  9: active-area row 0..479 driven to the layer stage.
REQ-008 Port pix_en  output  1: one-clk strobe per pixel period.
REQ-009 Port hs  output  1: horizontal sync, active low.
REQ-010 Port vs  output  1: vertical sync, active low.
REQ-011 Port rgb  output  12: colour to the DAC pins.
REQ-012 Port frame_end  output  1: one-clk pulse on the last pixel of each frame.

Function
REQ-013 Divider counts 0..PIX_DIV-1 and wraps; pix_en is high in the clk cycle where the divider equals PIX_DIV-1.
REQ-014 h_cnt advances only when pix_en is high; it wraps 799->0 (640 active, 16 front porch, 96 sync, 48 back porch).
REQ-015 v_cnt advances only when pix_en is high and h_cnt=799; it wraps 524->0 (480 active, 10 front porch, 2 sync, 33 back porch).
REQ-016 de_raw = (h_cnt<640) and (v_cnt<480).
REQ-017 vga_x = h_cnt when h_cnt<640, else 0; vga_y = v_cnt when v_cnt<480, else 0. Both are registered and change in the same cycle as the counters.
REQ-018 hs_raw is low for h_cnt in 656..751 inclusive and high otherwise; vs_raw is low for v_cnt in 490..491 inclusive and high otherwise.
REQ-019 hs_raw, vs_raw and de_raw pass through a shift pipeline of RD_LAT+1 clk stages; hs and vs are the last stage.
REQ-020 rgb is registered: it takes color_in when the delayed de is 1 and 12'h000 otherwise, so rgb, hs and vs stay cycle-aligned.
REQ-021 frame_end is high for exactly one clk, in the cycle where pix_en=1, h_cnt=799 and v_cnt=524; it is not delayed by the pipeline.
REQ-022 At the h_cnt and v_cnt wrap in the same pix_en, both counters go to 0 simultaneously with no intermediate value.
REQ-023 color_in is sampled every clk; values outside the delayed active window have no effect on rgb.

Reset
REQ-024 While rst=1: divider, h_cnt and v_cnt are 0; vga_x=0; vga_y=0; pix_en=0; frame_end=0; rgb=12'h000; hs=1; vs=1; all pipeline stages hold hs=1, vs=1, de=0.
REQ-025 Reset asserted mid-frame takes effect immediately, with no wait for a clk edge.
REQ-026 After rst deasserts, the first pix_en occurs PIX_DIV clk edges later and the frame restarts at h_cnt=0, v_cnt=0.

Configuration
REQ-027 Macro VGA_TIMING_BORDER_EN, when defined, forces rgb=12'hFFF in every active pixel at column 0, column 639, row 0 or row 479; elsewhere REQ-020 applies.
REQ-028 Without VGA_TIMING_BORDER_EN, rgb follows REQ-020 exactly and no border logic is synthesised.

Verification
REQ-029 Release rst, count clks -> pix_en every 4th clk; hs period 3200 clk; vs period 1,680,000 clk.
REQ-030 Hold color_in=12'hA5C with RD_LAT=1 -> rgb=12'hA5C exactly for the 640x480 active window, aligned to hs/vs; 12'h000 in blanking.
REQ-031 Pulse widths -> hs low for 96 pixels (384 clk) starting at h_cnt=656; vs low for 2 lines starting at v_cnt=490.
REQ-032 Run to h_cnt=799, v_cnt=524 -> frame_end high for one clk; next pixel shows vga_x=0, vga_y=0, with one pulse per frame.
REQ-033 Assert rst at h_cnt=300, v_cnt=200 between clk edges -> outputs reach reset values immediately; restart timing matches REQ-026.
REQ-034 With VGA_TIMING_BORDER_EN and color_in=12'h000 -> rgb=12'hFFF at (0,y), (639,y), (x,0) and (x,479); rgb=12'h000 at (320,240).
